// File: rtl/mips_main_control_fsm.sv
// ---------------------------------------------------------------------------
// mips_main_control_fsm: multicycle MIPS main control (Moore FSM, mem_ready handshake).
// Optional macro MAIN_FSM_ADDI_EN adds addi decode (ADDIEX/ADDIWB). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_main_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
`ifdef MAIN_FSM_ADDI_EN
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
`else
    S_JUMP   = 4'd10
`endif
  } state_t;

  state_t state_q, state_d;

  // Zero only feeds the datapath PC-enable logic; it never steers the FSM.
  logic unused_zero;
  assign unused_zero = Zero;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d     = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          C_OP_LW, C_OP_SW: state_d = S_MEMADR;
          C_OP_RTYPE:       state_d = S_EXEC;
          C_OP_BEQ:         state_d = S_BRANCH;
          C_OP_J:           state_d = S_JUMP;
`ifdef MAIN_FSM_ADDI_EN
          C_OP_ADDI:        state_d = S_ADDIEX;
`endif
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == C_OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef MAIN_FSM_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: RegWrite = 1'b1;
`endif
      default: state_d = S_FETCH;
    endcase
  end

`ifndef MAIN_FSM_ADDI_EN
  logic [5:0] unused_addi_op;
  assign unused_addi_op = C_OP_ADDI;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_main_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mips_main_control_fsm: directed self-checking bench for the main control FSM.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_main_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state)
  );

  // Word order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite ALUSrcA
  //             RegWrite RegDst ALUSrcB[1:0] PCSource[1:0] ALUOp[1:0] illegal_op
  function automatic logic [16:0] ctl(input logic pcw, pcwc, iord, mrd, mwr, m2r, irw,
                                      asa, rw, rd, input logic [1:0] asb, pcs, aop,
                                      input logic ill);
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, asb, pcs, aop, ill};
  endfunction

  logic [16:0] obs_word;
  assign obs_word = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                     ALUSrcA, RegWrite, RegDst, ALUSrcB, PCSource, ALUOp, illegal_op};

  logic [16:0] W_IDLE, W_FETCH_RDY, W_FETCH_WAIT, W_DECODE, W_DECODE_ILL, W_MEMADR;
  logic [16:0] W_MEMRD, W_MEMWB, W_MEMWR, W_EXEC, W_RWB, W_BRANCH, W_JUMP, W_ADDIWB;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_word);
    n_tests++;
    assert (state === exp_state)
      else begin
        n_fail++;
        $error("FAIL %s.state: observed %0d expected %0d", tag, state, exp_state);
      end
    n_tests++;
    assert (obs_word === exp_word)
      else begin
        n_fail++;
        $error("FAIL %s.ctl: observed %05h expected %05h", tag, obs_word, exp_word);
      end
  endtask

  initial begin
    W_IDLE       = '0;
    W_FETCH_RDY  = ctl(1,0,0,1,0,0,1,0,0,0,2'b01,2'b00,2'b00,0);
    W_FETCH_WAIT = ctl(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    W_DECODE     = ctl(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    W_DECODE_ILL = ctl(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
    W_MEMADR     = ctl(0,0,0,0,0,0,0,1,0,0,2'b10,2'b00,2'b00,0);
    W_MEMRD      = ctl(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    W_MEMWB      = ctl(0,0,0,0,0,1,0,0,1,0,2'b00,2'b00,2'b00,0);
    W_MEMWR      = ctl(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    W_EXEC       = ctl(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b10,0);
    W_RWB        = ctl(0,0,0,0,0,0,0,0,1,1,2'b00,2'b00,2'b00,0);
    W_BRANCH     = ctl(0,1,0,0,0,0,0,1,0,0,2'b00,2'b01,2'b01,0);
    W_JUMP       = ctl(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,0);
    W_ADDIWB     = ctl(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);

    rst_n = 1'b0; Op = 6'b000000; Zero = 1'b0; mem_ready = 1'b1;
    step(); step(); step();
    chk("reset", 4'd0, W_IDLE);
    rst_n = 1'b1;
    step(); chk("first_fetch", 4'd1, W_FETCH_RDY);

    // lw with memory always ready
    Op = 6'b100011;
    step(); chk("lw_decode", 4'd2, W_DECODE);
    Zero = 1'b1;
    step(); chk("lw_memadr", 4'd3, W_MEMADR);
    step(); chk("lw_memrd", 4'd4, W_MEMRD);
    step(); chk("lw_memwb", 4'd5, W_MEMWB);
    step(); chk("lw_fetch", 4'd1, W_FETCH_RDY);

    // sw with two wait cycles in MEMWR
    Op = 6'b101011;
    step(); chk("sw_decode", 4'd2, W_DECODE);
    step(); chk("sw_memadr", 4'd3, W_MEMADR);
    mem_ready = 1'b0;
    step(); chk("sw_memwr0", 4'd6, W_MEMWR);
    step(); chk("sw_memwr1", 4'd6, W_MEMWR);
    step(); chk("sw_memwr2", 4'd6, W_MEMWR);
    mem_ready = 1'b1;
    step(); chk("sw_fetch", 4'd1, W_FETCH_RDY);

    // R-type
    Op = 6'b000000;
    step(); chk("r_decode", 4'd2, W_DECODE);
    step(); chk("r_exec", 4'd7, W_EXEC);
    step(); chk("r_rwb", 4'd8, W_RWB);
    step(); chk("r_fetch", 4'd1, W_FETCH_RDY);

    // beq
    Op = 6'b000100;
    step(); chk("beq_decode", 4'd2, W_DECODE);
    step(); chk("beq_branch", 4'd9, W_BRANCH);
    step(); chk("beq_fetch", 4'd1, W_FETCH_RDY);

    // j
    Op = 6'b000010;
    step(); chk("j_decode", 4'd2, W_DECODE);
    step(); chk("j_jump", 4'd10, W_JUMP);
    step(); chk("j_fetch", 4'd1, W_FETCH_RDY);

    // illegal opcode
    Op = 6'b111111;
    step(); chk("ill_decode", 4'd2, W_DECODE_ILL);
    step(); chk("ill_fetch", 4'd1, W_FETCH_RDY);

    // addi: legal only when the option is built in
    Op = 6'b001000;
`ifdef MAIN_FSM_ADDI_EN
    step(); chk("addi_decode", 4'd2, W_DECODE);
    step(); chk("addi_ex", 4'd11, W_MEMADR);
    step(); chk("addi_wb", 4'd12, W_ADDIWB);
    step(); chk("addi_fetch", 4'd1, W_FETCH_RDY);
`else
    step(); chk("addi_decode_ill", 4'd2, W_DECODE_ILL);
    step(); chk("addi_fetch", 4'd1, W_FETCH_RDY);
`endif

    // FETCH stretched by four not-ready cycles
    Op = 6'b000000;
    mem_ready = 1'b0;
    #1; chk("fwait0", 4'd1, W_FETCH_WAIT);
    step(); chk("fwait1", 4'd1, W_FETCH_WAIT);
    step(); chk("fwait2", 4'd1, W_FETCH_WAIT);
    step(); chk("fwait3", 4'd1, W_FETCH_WAIT);
    mem_ready = 1'b1;
    #1; chk("fready", 4'd1, W_FETCH_RDY);
    step(); chk("fwait_decode", 4'd2, W_DECODE);
    step(); chk("fwait_exec", 4'd7, W_EXEC);
    step(); chk("fwait_rwb", 4'd8, W_RWB);
    step(); chk("fwait_fetch", 4'd1, W_FETCH_RDY);

    // reset while waiting in MEMRD
    Op = 6'b100011;
    step(); chk("rst_decode", 4'd2, W_DECODE);
    mem_ready = 1'b0;
    step(); chk("rst_memadr", 4'd3, W_MEMADR);
    step(); chk("rst_memrd0", 4'd4, W_MEMRD);
    step(); chk("rst_memrd1", 4'd4, W_MEMRD);
    rst_n = 1'b0;
    step(); chk("rst_mid_wait", 4'd0, W_IDLE);
    step(); chk("rst_hold", 4'd0, W_IDLE);
    rst_n = 1'b1; mem_ready = 1'b1;
    step(); chk("rst_refetch", 4'd1, W_FETCH_RDY);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_main_control_fsm.md
# mips_main_control_fsm

Multicycle main control unit for the MIPS datapath. A Moore state machine decodes the instruction opcode and produces, every cycle, the datapath control word: mux selects RegDst, IorD, MemtoReg, ALUSrcA, ALUSrcB and PCSource, memory strobes MemRead and MemWrite, and the register, IR and PC write enables. It sits directly upstream of the datapath mux/memory block and drives its select inputs. A memory-ready handshake stretches memory states so the unit also works with multi-cycle memory.

## Interface
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- Op  input  6  opcode, instruction bits [31:26], taken from the IR output
- Zero  input  1  ALU zero flag; used only by the datapath PC-enable logic, does not affect state
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls
- ALUSrcB  output  2  00=B, 01=constant 4, 10=sign-extended immediate, 11=shifted sign-extended immediate
- PCSource  output  2  00=ALUResult, 01=ALUOut, 10=jump concatenation
- ALUOp  output  2  00=add, 01=subtract, 10=use funct
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- state  output  4  current state, for debug

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12.
- Every output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=mem_ready and PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDIEX
  - any other opcode -> FETCH, with illegal_op=1 for that DECODE cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state FETCH.
- Undefined state codes 13-15 go to FETCH on the next cycle; all outputs are 0 while in them.
- Op is sampled only in DECODE and MEMADR.

## Timing
- The state register is the only storage.
- Outputs decode combinationally from state. The exceptions are IRWrite and PCWrite in FETCH, which are also qualified by mem_ready.
- rst_n=0 at a rising edge forces state=IDLE, from any state including mid-wait. All outputs are 0 while state=IDLE.
- The first FETCH occurs one cycle after rst_n is sampled high.
- Cycles per instruction with mem_ready tied high:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - illegal opcode: 2
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. The control outputs hold constant during the wait, except the FETCH enables, which stay 0.
- mem_ready is ignored in every other state.

## Configuration
- MAIN_FSM_ADDI_EN
  - Defined: addi (001000) is decoded and the ADDIEX and ADDIWB states exist.
  - Undefined: 001000 is treated as an illegal opcode (DECODE -> FETCH with an illegal_op pulse), and codes 11-12 behave as undefined states.

## Test plan
- Reset: hold rst_n=0 for 3 cycles in any state -> state=0 and all outputs 0. The cycle after release, state=1 with MemRead=1, ALUSrcB=01 and PCWrite=IRWrite=1 (mem_ready=1).
- lw (Op=100011), mem_ready=1 -> state sequence 1,2,3,4,5,1. In state 4, IorD=1 and MemRead=1. In state 5, RegWrite=1, MemtoReg=1 and RegDst=0.
- sw (Op=101011) with mem_ready low for 2 cycles in MEMWR -> state 6 lasts 3 cycles with MemWrite=1 and IorD=1 throughout, then returns to 1. RegWrite is never asserted.
- R-type, then beq (000100), then j (000010) -> sequences 1,2,7,8,1 / 1,2,9,1 / 1,2,10,1. Check ALUOp=10, then ALUOp=01 with PCWriteCond=1 and PCSource=01, then PCSource=10 with PCWrite=1.
- Op=111111 -> DECODE pulses illegal_op=1 for exactly one cycle, then state=1. Repeat with Op=001000 with MAIN_FSM_ADDI_EN undefined (pulses) and defined (sequence 1,2,11,12,1, no pulse).
- FETCH with mem_ready=0 for 4 cycles -> MemRead=1 and PCWrite=IRWrite=0 during the wait. PCWrite and IRWrite pulse once when mem_ready rises, and the next state is 2.
